// File: rtl/hpc1_pkg.sv
// hpc1_pkg: shared widths, FSM states and randomness byte map for hpc1_sched
package hpc1_pkg;
    localparam int NSHARES = 5;
    localparam int SHARE_W = 8;
    localparam int NRND = 14;
    localparam int NR = NSHARES - 1;
    localparam int NP = NSHARES * (NSHARES - 1) / 2;
    localparam int DW = NSHARES * SHARE_W;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;
    localparam int IDX_R0 = 0;
    localparam int IDX_R1 = 1;
    localparam int IDX_R2 = 2;
    localparam int IDX_R3 = 3;
    localparam int IDX_P01 = 4;
    localparam int IDX_P02 = 5;
    localparam int IDX_P03 = 6;
    localparam int IDX_P04 = 7;
    localparam int IDX_P12 = 8;
    localparam int IDX_P13 = 9;
    localparam int IDX_P14 = 10;
    localparam int IDX_P23 = 11;
    localparam int IDX_P24 = 12;
    localparam int IDX_P34 = 13;
    // Position of pair byte p_ij (unordered) within the p vector: 01,02,03,04,12,13,14,23,24,34.
    function automatic int pidx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (2 * NSHARES - lo - 1) / 2 + hi - lo - 1;
    endfunction
endpackage

// File: rtl/hpc1_sched_gadget.sv
// hpc1_gadget: 5-share, 8-bit HPC1 masked AND with a two-register latency
module hpc1_gadget
    import hpc1_pkg::*;
(
    input  logic                  clk,
    input  logic [DW-1:0]         a,
    input  logic [DW-1:0]         b,
    input  logic [NR*SHARE_W-1:0] r,
    input  logic [NP*SHARE_W-1:0] p,
    output logic [DW-1:0]         c
);
    logic [DW-1:0]          a_q, a_d, b_q, b_d;
    logic [NP*SHARE_W-1:0]  p_q, p_d;
    logic [NSHARES*DW-1:0]  u_q, u_d;
    logic [SHARE_W-1:0]     rsum;

    // Stage 1: refresh b with r (last share absorbs the sum of r), carry a and p alongside.
    always_comb begin
        rsum = '0;
        for (int i = 0; i < NR; i++) rsum ^= r[i*SHARE_W +: SHARE_W];
        a_d = a;
        p_d = p;
        b_d = b ^ {rsum, r};
    end

    // Stage 2: partial products a_i & b'_j, each off-diagonal term masked by its pair byte.
    always_comb begin
        u_d = '0;
        for (int i = 0; i < NSHARES; i++)
            for (int j = 0; j < NSHARES; j++)
                u_d[(i*NSHARES+j)*SHARE_W +: SHARE_W] =
                    (a_q[i*SHARE_W +: SHARE_W] & b_q[j*SHARE_W +: SHARE_W]) ^
                    ((i == j) ? '0 : p_q[pidx(i, j)*SHARE_W +: SHARE_W]);
    end

    // Compression: each output share folds its row of registered partial products.
    always_comb begin
        c = '0;
        for (int i = 0; i < NSHARES; i++)
            for (int j = 0; j < NSHARES; j++)
                c[i*SHARE_W +: SHARE_W] ^= u_q[(i*NSHARES+j)*SHARE_W +: SHARE_W];
    end

    // Pipeline registers are unreset; the controller only looks at c in WAIT2.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        p_q <= p_d;
        u_q <= u_d;
    end
endmodule

// File: rtl/hpc1_sched.sv
// hpc1_sched: randomness collection, one-shot issue and result handshake around an HPC1 gadget
module hpc1_sched
    import hpc1_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rnd_valid,
    input  logic [7:0]    rnd_data,
    output logic          rnd_ready,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_c,
    input  logic          out_ready
);
    state_e                   state_q, state_d;
    logic [3:0]               rcnt_q, rcnt_d;
    logic [NRND*SHARE_W-1:0]  buf_q, buf_d;
    logic [DW-1:0]            a_q, a_d, b_q, b_d, c_q, c_d;
    logic                     issue, rnd_acc, in_acc;
    logic [DW-1:0]            g_a, g_b, g_c;
    logic [NR*SHARE_W-1:0]    g_r;
    logic [NP*SHARE_W-1:0]    g_p;

    // Handshake readies and gating of everything the gadget sees outside ISSUE.
    always_comb begin
        issue     = state_q == ST_ISSUE;
        rnd_ready = (rcnt_q < 4'(NRND)) && !issue;
        in_ready  = (state_q == ST_IDLE) && (rcnt_q == 4'(NRND));
        out_valid = state_q == ST_HOLD;
        out_c     = c_q;
        rnd_acc   = rnd_valid && rnd_ready;
        in_acc    = in_valid && in_ready;
        g_a       = issue ? a_q : '0;
        g_b       = issue ? b_q : '0;
        g_r       = issue ? buf_q[IDX_P01*SHARE_W-1:IDX_R0*SHARE_W] : '0;
        g_p       = issue ? buf_q[NRND*SHARE_W-1:IDX_P01*SHARE_W] : '0;
    end

    // Next state: buffer fill, operand capture, issue with buffer wipe, result capture.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        buf_d   = buf_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        if (rnd_acc) begin
            rcnt_d = rcnt_q + 4'd1;
            for (int i = 0; i < NRND; i++)
                if (rcnt_q == 4'(i)) buf_d[i*SHARE_W +: SHARE_W] = rnd_data;
        end
        case (state_q)
            ST_IDLE: if (in_acc) begin
                a_d     = in_a;
                b_d     = in_b;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                rcnt_d  = '0;
                buf_d   = '0;
                a_d     = '0;
                b_d     = '0;
                state_d = ST_WAIT1;
            end
            ST_WAIT1: state_d = ST_WAIT2;
            ST_WAIT2: begin
                c_d     = g_c;
                state_d = ST_HOLD;
            end
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            buf_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            buf_q   <= buf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    hpc1_gadget u_hpc1 (
        .clk (clk),
        .a   (g_a),
        .b   (g_b),
        .r   (g_r),
        .p   (g_p),
        .c   (g_c)
    );
endmodule

// File: tb/tb_hpc1_sched.sv
// tb_hpc1_sched: directed and randomized checks of hpc1_sched against a transaction-level model
module tb_hpc1_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rnd_valid = 1'b0;
    logic [7:0]  rnd_data = '0;
    logic        rnd_ready;
    logic        in_valid = 1'b0;
    logic [39:0] in_a = '0;
    logic [39:0] in_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_c;
    logic        out_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_res = 0;
    logic rand_phase = 1'b0;

    hpc1_sched dut (
        .clk(clk), .rst(rst),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .out_valid(out_valid), .out_c(out_c), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xor5(input logic [39:0] s);
        return s[7:0] ^ s[15:8] ^ s[23:16] ^ s[31:24] ^ s[39:32];
    endfunction

    function automatic logic [39:0] split(input logic [7:0] v);
        logic [39:0] s;
        s[31:0] = $urandom;
        s[39:32] = v ^ s[7:0] ^ s[15:8] ^ s[23:16] ^ s[31:24];
        return s;
    endfunction

    // Transaction model: an operation occupies the controller for "age" cycles after its handshake;
    // age 0 is the issue cycle, age >= 3 means the product is on offer. The random buffer is just
    // the bytes accepted since the last issue.
    logic         armed = 1'b0;
    logic         busy = 1'b0;
    int           age = 0;
    logic [39:0]  ma = '0, mb = '0;
    logic [111:0] mbuf = '0;
    int           mcnt = 0;
    logic [39:0]  held = '0;
    logic         held_ok = 1'b0;

    always @(negedge clk) begin
        logic e_rr, e_ir, e_ov, iss;
        iss  = busy && age == 0;
        e_rr = mcnt < 14 && !iss;
        e_ir = !busy && mcnt == 14;
        e_ov = busy && age >= 3;
        if (armed) begin
            chk("rnd_ready", rnd_ready, e_rr);
            chk("in_ready", in_ready, e_ir);
            chk("out_valid", out_valid, e_ov);
            if (e_ov) begin
                chk("product", xor5(out_c), xor5(ma) & xor5(mb));
                if (rand_phase) chk("product F0&33", xor5(out_c), 8'h30);
                if (held_ok) chk("out_c stable", out_c, held);
                held = out_c;
                held_ok = 1'b1;
            end
            if (iss) begin
                chk("gadget a", dut.u_hpc1.a, ma);
                chk("gadget b", dut.u_hpc1.b, mb);
                chk("gadget rnd", {dut.u_hpc1.p, dut.u_hpc1.r}, mbuf);
            end else
                chk("gadget idle zero", |{dut.u_hpc1.a, dut.u_hpc1.b, dut.u_hpc1.r, dut.u_hpc1.p}, 1'b0);
            if (iss) begin
                mbuf = '0;
                mcnt = 0;
            end else if (rnd_valid && e_rr) begin
                mbuf[mcnt*8 +: 8] = rnd_data;
                mcnt++;
            end
            if (e_ov && out_ready) begin
                busy = 1'b0;
                held_ok = 1'b0;
                n_res++;
            end else if (busy) age++;
            if (in_valid && e_ir) begin
                busy = 1'b1;
                age = 0;
                ma = in_a;
                mb = in_b;
            end
        end
        if (rst) begin
            armed = 1'b1;
            busy = 1'b0;
            mbuf = '0;
            mcnt = 0;
            ma = '0;
            mb = '0;
            held_ok = 1'b0;
        end
    end

    task automatic send_op(input logic [39:0] a, input logic [39:0] b);
        logic took;
        took = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 100 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("operand accepted", took, 1'b1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk("out_valid seen", out_valid, 1'b1);
    endtask

    initial begin
        int n;
        int base;
        logic took;
        logic [39:0] hv;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Fill from reset with 0x01..0x0E; a 15th byte must be refused.
        rnd_valid = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            rnd_data = 8'(i);
            @(posedge clk);
            #1;
        end
        rnd_data = 8'h0F;
        @(negedge clk);
        chk("full rnd_ready", rnd_ready, 1'b0);
        chk("full in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rnd_valid = 1'b0;
        // Single operation 0x5A & 0x3C with unsplit shares.
        send_op(40'h5A, 40'h3C);
        @(negedge clk);
        chk("issue r bytes", dut.u_hpc1.r, 32'h04030201);
        chk("issue p01 byte", dut.u_hpc1.p[7:0], 8'h05);
        wait_valid(n);
        chk("latency", n + 1, 4);
        chk("product 5A&3C", xor5(out_c), 8'h18);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        // 200 randomized operations on split shares of 0xF0 and 0x33.
        rand_phase = 1'b1;
        base = n_res;
        in_a = split(8'hF0);
        in_b = split(8'h33);
        for (int cyc = 0; cyc < 20000 && n_res < base + 200; cyc++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took || !in_valid) begin
                in_valid = $urandom_range(0, 2) != 0;
                in_a = split(8'hF0);
                in_b = split(8'h33);
            end
            rnd_valid = $urandom_range(0, 3) != 0;
            rnd_data = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
        end
        chk("random ops done", n_res - base >= 200, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rnd_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rand_phase = 1'b0;
        // Result held with out_ready low while randomness saturates.
        out_ready = 1'b0;
        send_op(split(8'hA5), split(8'h0F));
        wait_valid(n);
        hv = out_c;
        repeat (16) begin
            @(negedge clk);
            chk("hold out_c", out_c, hv);
            chk("hold in_ready", in_ready, 1'b0);
        end
        chk("hold rnd_ready", rnd_ready, 1'b0);
        chk("hold product", xor5(out_c), 8'h05);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = split(8'hC3);
        in_b = split(8'hFF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk("release product", xor5(out_c), 8'hC3);
        repeat (6) @(posedge clk);
        #1;
        // Reset during WAIT1 discards the in-flight operation.
        send_op(split(8'h77), split(8'h11));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst rnd_ready", rnd_ready, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("no result after rst", out_valid, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
